// File: rtl/ibex_rf_sched_pkg.sv
// Shared types and helpers for the register-file write scheduler.
//   rf_sched_state_e : scheduler phase (zeroing sweep / normal run)
//   rf_wr_req_t      : one register-file write request (address + data)
package ibex_rf_sched_pkg;

   localparam int unsigned RegAddrWidth = 5;
   localparam int unsigned RfDataWidth  = 32;

   typedef enum logic {
      RF_INIT,
      RF_RUN
   } rf_sched_state_e;

   typedef struct packed {
      logic [RegAddrWidth-1:0] waddr;
      logic [RfDataWidth-1:0]  wdata;
   } rf_wr_req_t;

   // Number of significant register address bits for the chosen ISA variant.
   function automatic int unsigned rf_addr_width(bit rv32e);
      return rv32e ? 4 : 5;
   endfunction

endpackage

// File: rtl/ibex_rf_wr_fifo.sv
// Small circular FIFO holding buffered LSU register writes.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   push_i, push_addr_i/data_i   enqueue one write (caller guarantees !full_o)
//   pop_i                   dequeue the head (caller guarantees !empty_o)
//   full_o, empty_o, count_o     occupancy
//   head_addr_o, head_data_o     oldest buffered write
//   valid_o, addr_o         per-slot valid flags and flattened addresses
module ibex_rf_wr_fifo #(
   parameter  int unsigned Depth     = 2,
   parameter  int unsigned AddrWidth = 5,
   parameter  int unsigned DataWidth = 32,
   localparam int unsigned PtrWidth  = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int unsigned CntWidth  = $clog2(Depth + 1)
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         push_i,
   input  logic [AddrWidth-1:0]         push_addr_i,
   input  logic [DataWidth-1:0]         push_data_i,
   input  logic                         pop_i,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [CntWidth-1:0]          count_o,
   output logic [AddrWidth-1:0]         head_addr_o,
   output logic [DataWidth-1:0]         head_data_o,
   output logic [Depth-1:0]             valid_o,
   output logic [Depth*AddrWidth-1:0]   addr_o
);

   logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntWidth-1:0]  count_q;
   logic [Depth-1:0]     valid_q;
   logic [AddrWidth-1:0] addr_q [Depth];
   logic [DataWidth-1:0] data_q [Depth];

   // Pointer advance with wrap at Depth (Depth need not be a power of two).
   function automatic logic [PtrWidth-1:0] ptr_inc(logic [PtrWidth-1:0] p);
      return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
   endfunction

   // Control state; per-slot valid flags let the top compare addresses directly.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
      end else begin
         if (push_i) begin
            valid_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q          <= ptr_inc(wr_ptr_q);
         end
         if (pop_i) begin
            valid_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q          <= ptr_inc(rd_ptr_q);
         end
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CntWidth'(1);
            2'b01:   count_q <= count_q - CntWidth'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Payload storage needs no reset: slots are qualified by valid_q.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         addr_q[wr_ptr_q] <= push_addr_i;
         data_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_comb begin
      addr_o = '0;
      for (int unsigned i = 0; i < Depth; i++) begin
         addr_o[i*AddrWidth +: AddrWidth] = addr_q[i];
      end
   end

   assign full_o      = (count_q == CntWidth'(Depth));
   assign empty_o     = (count_q == '0);
   assign count_o     = count_q;
   assign valid_o     = valid_q;
   assign head_addr_o = addr_q[rd_ptr_q];
   assign head_data_o = data_q[rd_ptr_q];

endmodule

// File: rtl/ibex_rf_write_scheduler.sv
// Owns the single register-file write port. After reset it zeroes x1..xN-1,
// then arbitrates between zero-latency EX writes and buffered LSU writes,
// and flags read-after-write hazards against still-buffered LSU writes.
// Ports:
//   clk_i, rst_i                         clock, asynchronous active-high reset
//   ex_we_i/ex_waddr_i/ex_wdata_i        EX write request, ex_ready_o accept
//   lsu_we_i/lsu_waddr_i/lsu_wdata_i     LSU write request, lsu_ready_o accept
//   raddr_a_i/raddr_b_i                  read addresses, hazard_a_o/hazard_b_o
//   rf_we_o/rf_waddr_o/rf_wdata_o        register-file write port
//   init_done_o                          zeroing sweep finished
module ibex_rf_write_scheduler import ibex_rf_sched_pkg::*; #(
   parameter bit          RV32E     = 1'b0,
   parameter int unsigned DataWidth = RfDataWidth,
   parameter int unsigned LsuDepth  = 2,
   parameter bit          InitZero  = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 ex_we_i,
   input  logic [4:0]           ex_waddr_i,
   input  logic [DataWidth-1:0] ex_wdata_i,
   output logic                 ex_ready_o,
   input  logic                 lsu_we_i,
   input  logic [4:0]           lsu_waddr_i,
   input  logic [DataWidth-1:0] lsu_wdata_i,
   output logic                 lsu_ready_o,
   input  logic [4:0]           raddr_a_i,
   input  logic [4:0]           raddr_b_i,
   output logic                 hazard_a_o,
   output logic                 hazard_b_o,
   output logic                 rf_we_o,
   output logic [4:0]           rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o,
   output logic                 init_done_o
);

   localparam int unsigned AddrWidth = rf_addr_width(RV32E);
   localparam int unsigned NumWords  = 2 ** AddrWidth;
   localparam int unsigned CntWidth  = $clog2(LsuDepth + 1);

   rf_sched_state_e        state_q;
   logic [AddrWidth-1:0]   sweep_q;

   logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CntWidth-1:0]    fifo_count;
   logic [AddrWidth-1:0]   fifo_head_addr;
   logic [DataWidth-1:0]   fifo_head_data;
   logic [LsuDepth-1:0]    fifo_valid;
   logic [LsuDepth*AddrWidth-1:0] fifo_addr;

   logic [AddrWidth-1:0]   ex_addr, lsu_addr, ra_addr, rb_addr;
   logic                   is_run, waw_hit, hit_a, hit_b, ex_write;

   // High address bit is dropped in RV32E.
   assign ex_addr  = ex_waddr_i[AddrWidth-1:0];
   assign lsu_addr = lsu_waddr_i[AddrWidth-1:0];
   assign ra_addr  = raddr_a_i[AddrWidth-1:0];
   assign rb_addr  = raddr_b_i[AddrWidth-1:0];

   // Phase FSM and sweep counter; the sweep ends after writing x(N-1).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= InitZero ? RF_INIT : RF_RUN;
         sweep_q <= AddrWidth'(1);
      end else if (state_q == RF_INIT) begin
         sweep_q <= sweep_q + AddrWidth'(1);
         if (sweep_q == AddrWidth'(NumWords - 1)) begin
            state_q <= RF_RUN;
         end
      end
   end

   assign is_run      = (state_q == RF_RUN);
   assign init_done_o = is_run;

   // Address match of EX and both read ports against every buffered write.
   always_comb begin
      waw_hit = 1'b0;
      hit_a   = 1'b0;
      hit_b   = 1'b0;
      for (int unsigned i = 0; i < LsuDepth; i++) begin
         if (fifo_valid[i]) begin
            if (fifo_addr[i*AddrWidth +: AddrWidth] == ex_addr) waw_hit = 1'b1;
            if (fifo_addr[i*AddrWidth +: AddrWidth] == ra_addr) hit_a   = 1'b1;
            if (fifo_addr[i*AddrWidth +: AddrWidth] == rb_addr) hit_b   = 1'b1;
         end
      end
   end

   assign hazard_a_o  = hit_a && (ra_addr != '0);
   assign hazard_b_o  = hit_b && (rb_addr != '0);

   // EX yields to a full FIFO and to an older buffered write to the same register.
   assign ex_ready_o  = is_run && !fifo_full && !(waw_hit && (ex_addr != '0));
   assign ex_write    = ex_we_i && ex_ready_o && (ex_addr != '0);
   assign fifo_pop    = is_run && !fifo_empty && (fifo_full || !ex_write);
   assign lsu_ready_o = is_run && !fifo_full;
   assign fifo_push   = lsu_we_i && lsu_ready_o && (lsu_addr != '0);

   // Write-port mux: sweep, then FIFO drain (already prioritised), then EX.
   always_comb begin
      rf_we_o    = 1'b0;
      rf_waddr_o = '0;
      rf_wdata_o = '0;
      if (!is_run) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = 5'(sweep_q);
      end else if (fifo_pop) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = 5'(fifo_head_addr);
         rf_wdata_o = fifo_head_data;
      end else if (ex_write) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = 5'(ex_addr);
         rf_wdata_o = ex_wdata_i;
      end
   end

   ibex_rf_wr_fifo #(
      .Depth     (LsuDepth),
      .AddrWidth (AddrWidth),
      .DataWidth (DataWidth)
   ) u_lsu_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (fifo_push),
      .push_addr_i (lsu_addr),
      .push_data_i (lsu_wdata_i),
      .pop_i       (fifo_pop),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count),
      .head_addr_o (fifo_head_addr),
      .head_data_o (fifo_head_data),
      .valid_o     (fifo_valid),
      .addr_o      (fifo_addr)
   );

   // Occupancy can never exceed the configured depth.
   a_fifo_bound: assert property (@(posedge clk_i) disable iff (rst_i)
      fifo_count <= CntWidth'(LsuDepth));

endmodule

// File: tb/tb_ibex_rf_write_scheduler.sv
// Randomised scoreboard bench for ibex_rf_write_scheduler (RV32I, depth 2).
module tb_ibex_rf_write_scheduler;
   import ibex_rf_sched_pkg::*;

   localparam int unsigned Depth    = 2;
   localparam int unsigned NumWords = 32;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        ex_we_i, lsu_we_i;
   logic [4:0]  ex_waddr_i, lsu_waddr_i, raddr_a_i, raddr_b_i;
   logic [31:0] ex_wdata_i, lsu_wdata_i;
   logic        ex_ready_o, lsu_ready_o, hazard_a_o, hazard_b_o;
   logic        rf_we_o, init_done_o;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;

   always #5 clk = ~clk;

   ibex_rf_write_scheduler #(
      .RV32E(1'b0), .DataWidth(32), .LsuDepth(Depth), .InitZero(1'b1)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
      .ex_ready_o(ex_ready_o),
      .lsu_we_i(lsu_we_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
      .lsu_ready_o(lsu_ready_o),
      .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
      .hazard_a_o(hazard_a_o), .hazard_b_o(hazard_b_o),
      .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .init_done_o(init_done_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   rf_wr_req_t  exp_q[$];   // expected port writes, oldest first
   rf_wr_req_t  pend[$];    // model of buffered LSU writes
   logic [31:0] model_rf [NumWords];
   logic [31:0] dut_rf   [NumWords];
   bit          m_init;
   int          m_sweep;

   bit          ex_v, lsu_v;
   logic [4:0]  ex_a, lsu_a, ra, rb;
   logic [31:0] ex_d, lsu_d;
   rf_wr_req_t  mon_e;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_ex(logic [4:0] a, logic [31:0] d);
      ex_v = 1'b1; ex_a = a; ex_d = d;
   endtask

   task automatic set_lsu(logic [4:0] a, logic [31:0] d);
      lsu_v = 1'b1; lsu_a = a; lsu_d = d;
   endtask

   task automatic model_reset();
      pend.delete();
      m_init  = 1'b1;
      m_sweep = 1;
      ex_v    = 1'b0;
      lsu_v   = 1'b0;
   endtask

   // One clock cycle: entered and left at posedge+1.
   task automatic run_cycle();
      rf_wr_req_t w;
      bit wv, er, lr, ha, hb, conf, full, done, ex_wr;
      ex_we_i = ex_v;   ex_waddr_i = ex_a;   ex_wdata_i = ex_d;
      lsu_we_i = lsu_v; lsu_waddr_i = lsu_a; lsu_wdata_i = lsu_d;
      raddr_a_i = ra;   raddr_b_i = rb;
      w = '0; wv = 0; ha = 0; hb = 0; conf = 0;
      done = !m_init;
      if (m_init) begin
         wv = 1; w.waddr = 5'(m_sweep); w.wdata = '0;
         er = 0; lr = 0;
         if (m_sweep == NumWords - 1) m_init = 1'b0;
         m_sweep++;
      end else begin
         foreach (pend[i]) begin
            if (ra != 0 && pend[i].waddr == ra) ha = 1;
            if (rb != 0 && pend[i].waddr == rb) hb = 1;
            if (ex_a != 0 && pend[i].waddr == ex_a) conf = 1;
         end
         full  = (pend.size() == Depth);
         er    = !full && !conf;
         lr    = !full;
         ex_wr = ex_v && er && (ex_a != 0);
         if (full || (pend.size() > 0 && !ex_wr)) begin
            wv = 1; w = pend.pop_front();
         end else if (ex_wr) begin
            wv = 1; w.waddr = ex_a; w.wdata = ex_d;
         end
         if (lsu_v && lr && lsu_a != 0) begin
            rf_wr_req_t p;
            p.waddr = lsu_a; p.wdata = lsu_d;
            pend.push_back(p);
         end
      end
      if (wv) begin
         exp_q.push_back(w);
         model_rf[w.waddr] = w.wdata;
      end
      #1;
      chk("ex_ready", ex_ready_o, er);
      chk("lsu_ready", lsu_ready_o, lr);
      chk("hazard_a", hazard_a_o, ha);
      chk("hazard_b", hazard_b_o, hb);
      chk("init_done", init_done_o, done);
      if (!wv) chk("idle_port", {rf_we_o, rf_waddr_o, rf_wdata_o}, 64'd0);
      if (ex_v && er) ex_v = 1'b0;
      if (lsu_v && lr) lsu_v = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every write the DUT presents must be the next expected one.
   always @(negedge clk) begin
      if (!rst_i && rf_we_o) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got x%0d=%0h expected none at %0t",
                     rf_waddr_o, rf_wdata_o, $time);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", 64'(rf_waddr_o), 64'(mon_e.waddr));
            chk("wr_data", 64'(rf_wdata_o), 64'(mon_e.wdata));
         end
         dut_rf[rf_waddr_o] = rf_wdata_o;
      end
   end

   initial begin
      for (int i = 0; i < NumWords; i++) begin
         model_rf[i] = '0;
         dut_rf[i]   = '0;
      end
      ex_a = '0; ex_d = '0; lsu_a = '0; lsu_d = '0; ra = '0; rb = '0;
      ex_we_i = 0; lsu_we_i = 0; ex_waddr_i = '0; lsu_waddr_i = '0;
      ex_wdata_i = '0; lsu_wdata_i = '0; raddr_a_i = '0; raddr_b_i = '0;
      model_reset();
      rst_i = 1'b1;
      #2;
      chk("rst_init_done", init_done_o, 1'b0);
      chk("rst_ex_ready", ex_ready_o, 1'b0);
      chk("rst_lsu_ready", lsu_ready_o, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;

      // Zeroing sweep x1..x31, then the first RUN cycle.
      repeat (NumWords) run_cycle();

      // EX zero-latency write.
      set_ex(5'd5, 32'hDEADBEEF);
      run_cycle();

      // LSU x7 buffered behind a busy EX, then drained on an EX-idle cycle.
      set_lsu(5'd7, 32'h11);
      ra = 5'd7;
      for (int c = 0; c < 3; c++) begin
         if (!ex_v) set_ex(5'd3, $urandom);
         run_cycle();
      end
      repeat (2) run_cycle();

      // Fill the FIFO with x8, x9 while EX stays busy.
      set_lsu(5'd8, 32'h88);
      for (int c = 0; c < 5; c++) begin
         if (!ex_v) set_ex(5'd3, $urandom);
         if (!lsu_v && c == 1) set_lsu(5'd9, 32'h99);
         run_cycle();
      end
      repeat (3) run_cycle();

      // WAW: LSU x10=A buffered, EX x10=B must wait for it.
      set_lsu(5'd10, 32'hA);
      set_ex(5'd3, 32'h33);
      run_cycle();
      set_ex(5'd10, 32'hB);
      rb = 5'd10;
      repeat (4) run_cycle();
      chk("x10_final", dut_rf[10], 32'hB);

      // LSU write to x0 is accepted and discarded.
      set_lsu(5'd0, 32'h1234);
      repeat (2) run_cycle();

      // Randomised traffic with a narrow address range to provoke conflicts.
      for (int c = 0; c < 400; c++) begin
         if (!ex_v && $urandom_range(0, 2) != 0)
            set_ex(5'($urandom_range(0, 12)), $urandom);
         if (!lsu_v && $urandom_range(0, 2) == 0)
            set_lsu(5'($urandom_range(0, 12)), $urandom);
         ra = 5'($urandom_range(0, 12));
         rb = 5'($urandom_range(0, 12));
         run_cycle();
      end
      ex_v = 1'b0;
      lsu_v = 1'b0;
      repeat (4) run_cycle();

      // Reset with one entry queued: FIFO flushed, sweep restarts at x1.
      set_ex(5'd3, 32'h3);
      set_lsu(5'd12, 32'hC);
      run_cycle();
      set_ex(5'd3, 32'h4);
      ra = 5'd12;
      run_cycle();
      rst_i = 1'b1;
      model_reset();
      #1;
      chk("rst_hazard_a", hazard_a_o, 1'b0);
      chk("rst_sweep_addr", 64'(rf_waddr_o), 64'd1);
      chk("rst_mid_done", init_done_o, 1'b0);
      @(posedge clk);
      #1 rst_i = 1'b0;
      repeat (NumWords) run_cycle();
      repeat (2) run_cycle();

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      for (int i = 1; i < NumWords; i++) begin
         chk("regfile", 64'(dut_rf[i]), 64'(model_rf[i]));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ibex_rf_write_scheduler.md
Name: ibex_rf_write_scheduler

Overview:
Sequences the single write port of the flip-flop register file and shares it between two writeback requesters: the EX fast path and the LSU load-return path.
After reset it runs a zeroing sweep over x1..xN-1, because the register file has no reset on its storage.
In normal operation, EX writes have zero latency. LSU writes are buffered in a small FIFO and drained into idle port cycles.
It also reports read-after-write hazards on the two read addresses against writes that are still buffered.

Parameters:
RV32E, 0, 1 = 16 registers (ADDR_WIDTH 4), 0 = 32 registers (ADDR_WIDTH 5); NUM_WORDS = 2**ADDR_WIDTH.
DataWidth, 32, width of the write data.
LsuDepth, 2, number of LSU write FIFO entries (>=1).
InitZero, 1, 1 = run the zeroing sweep after reset; 0 = enter RUN directly.

Ports:
clk_i  in  1  clock, all state updates on the rising edge.
rst_i  in  1  asynchronous, active-high reset.
ex_we_i  in  1  EX write request valid.
ex_waddr_i  in  5  EX destination register.
ex_wdata_i  in  DataWidth  EX write data.
ex_ready_o  out  1  EX request accepted this cycle.
lsu_we_i  in  1  LSU write request valid.
lsu_waddr_i  in  5  LSU destination register.
lsu_wdata_i  in  DataWidth  LSU write data.
lsu_ready_o  out  1  LSU request accepted (enqueued) this cycle.
raddr_a_i  in  5  register file read address A.
raddr_b_i  in  5  register file read address B.
hazard_a_o  out  1  raddr_a_i matches a buffered LSU write.
hazard_b_o  out  1  raddr_b_i matches a buffered LSU write.
rf_we_o  out  1  register file write enable.
rf_waddr_o  out  5  register file write address.
rf_wdata_o  out  DataWidth  register file write data.
init_done_o  out  1  zeroing sweep complete.

Behaviour:
- Interface: one clock (clk_i); reset rst_i is asynchronous and active-high.
- Reset state:
  - FSM = INIT if InitZero, else RUN.
  - sweep counter = 1.
  - FIFO empty; read/write pointers and count = 0.
  - init_done_o = 0 in INIT, 1 in RUN.
- Reset asserted mid-operation: FIFO contents are discarded and the sweep restarts from x1.
- Handshake: a request transfers when we_i && ready_o in the same cycle. A requester holds its request stable until accepted.
- INIT state:
  - rf_we_o = 1, rf_waddr_o = counter, rf_wdata_o = 0.
  - counter increments every cycle.
  - When counter == NUM_WORDS-1, move to RUN on the next edge.
  - Sweep takes exactly NUM_WORDS-1 cycles.
  - ex_ready_o = 0 and lsu_ready_o = 0 throughout; hazard outputs = 0.
- RUN, port arbitration each cycle (priority order):
  - (1) FIFO full: drain the FIFO head to the port; ex_ready_o = 0.
  - (2) EX request with a valid address: drive the port from EX with zero latency; ex_ready_o = 1.
  - (3) FIFO not empty: drain the head.
  - (4) Otherwise rf_we_o = 0. rf_waddr_o / rf_wdata_o are don't-care but must be 0.
- WAW ordering: if ex_waddr_i matches any valid FIFO entry (non-zero address), ex_ready_o = 0. EX stalls until that entry drains.
- Writes to x0:
  - An EX write to x0 is accepted (ex_ready_o = 1) and dropped: rf_we_o = 0 from EX, and the FIFO may drain that cycle.
  - An LSU write to x0 is accepted and not enqueued.
- LSU enqueue:
  - lsu_ready_o = !full, registered-state only (no combinational path from lsu_we_i).
  - Enqueue and dequeue in the same cycle are allowed when not full; count is unchanged.
  - Minimum LSU write latency is 1 cycle.
  - FIFO pointers wrap modulo LsuDepth.
- Hazards:
  - hazard_x_o = raddr_x_i != 0 && any valid FIFO entry has waddr == raddr_x_i.
  - Purely combinational over current FIFO state.
  - An entry draining this cycle still flags a hazard this cycle.
- RV32E: address bit 4 is ignored on all inputs; addresses are compared as ADDR_WIDTH bits.

Decomposition:
- Package ibex_rf_sched_pkg holds:
  - rf_sched_state_e {RF_INIT, RF_RUN}.
  - struct rf_wr_req_t {logic [4:0] waddr; logic [DataWidth-1:0] wdata}.
- One sub-module, ibex_rf_wr_fifo:
  - parameterised by depth and width.
  - ports: push/pop/full/empty/count, plus a flattened entry-valid and address array for hazard/WAW compare.
- Arbitration and the FSM stay in the top module.

Test Plan:
- Reset with RV32E=0, InitZero=1, release rst_i -> rf_we_o=1 with waddr 1..31 and wdata 0 over 31 cycles; init_done_o rises on cycle 32; ready outputs are 0 throughout.
- RUN, idle FIFO; EX writes x5=0xDEADBEEF -> same cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF, ex_ready_o=1.
- LSU writes x7=0x11 while EX writes x3 every cycle -> FIFO holds x7; hazard_a_o=1 when raddr_a_i=7; x7 is written on the first EX-idle cycle, after which the hazard clears.
- Fill FIFO (LsuDepth=2) with x8, x9 while EX stays busy -> lsu_ready_o=0; the next cycle drains x8 with ex_ready_o=0; EX resumes the following cycle.
- LSU x10=0xA queued, then EX x10=0xB -> ex_ready_o=0 until x10=0xA is written; EX then writes 0xB; final register value is 0xB.
- LSU write to x0 -> accepted, nothing enqueued, no rf_we_o. Assert rst_i mid-queue with 1 entry -> FIFO empties, the sweep restarts at x1, and hazard outputs go to 0.
